// File: rtl/filter_dac_pkg.sv
// Shared definitions for the filter DAC output stage.
// FILTER_DAC_OFFSET_BIN_EN selects offset-binary output codes (MSB inverted);
// when undefined, the two's-complement sample is sent unchanged.
package filter_dac_pkg;

    localparam int FRAME_BITS = 24;
    localparam int CODE_BITS  = 16;
    localparam logic [7:0] DAC_CMD_DEFAULT = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } dac_state_t;

    // Map a filter sample to the code the DAC expects.
    function automatic logic [CODE_BITS-1:0] sample_to_code(input logic [CODE_BITS-1:0] s);
`ifdef FILTER_DAC_OFFSET_BIN_EN
        return {~s[CODE_BITS-1], s[CODE_BITS-2:0]};
`else
        return s;
`endif
    endfunction

endpackage

// File: rtl/filter_dac_out_fifo.sv
// dac_sample_fifo: small synchronous FIFO buffering converted DAC codes.
// Push on full and pop on empty are ignored; push and pop together keep the level.
module dac_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/filter_dac_out.sv
// filter_dac_out: captures filter samples on the rising edge of an async strobe,
// buffers them, and ships each as a 24-bit SPI frame {DAC_CMD, code} MSB first.
// Build option FILTER_DAC_OFFSET_BIN_EN: send offset-binary codes instead of
// two's complement (see filter_dac_pkg::sample_to_code).
//
// SPI handshake: a frame is {cs_n low for LOAD + SHIFT}; the DAC samples sdo on
// rising sclk, sdo only changes on falling sclk (or while sclk idles low in LOAD).
module filter_dac_out
    import filter_dac_pkg::*;
#(
    parameter int         CLK_DIV    = 1,
    parameter int         FIFO_DEPTH = 4,
    parameter int         GAP_CYC    = 2,
    parameter logic [7:0] DAC_CMD    = DAC_CMD_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          out_f_s,
    input  logic signed [15:0]            din,
    input  logic                          ovf_clr,
    output logic                          dac_sclk,
    output logic                          dac_cs_n,
    output logic                          dac_sdo,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output dac_state_t                    dbg_state
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
    localparam logic [4:0]  TOP_BIT  = 5'(FRAME_BITS - 1);

    // strobe synchronizer and capture
    logic [2:0]            sync_q;
    logic                  capture;
    logic                  push;
    logic                  ovf_q, ovf_d;

    // FIFO interface
    logic                  pop;
    logic [CODE_BITS-1:0]  fifo_data;
    logic                  fifo_full, fifo_empty;

    // FSM and serializer
    dac_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [4:0]            bit_q, bit_d;
    logic [15:0]           div_q, div_d;
    logic                  last_q, last_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sdo_q, sdo_d;
    logic                  done_q, done_d;

    // Three-flop synchronizer; a capture fires once per rising strobe edge.
    always_ff @(posedge clk) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[1:0], out_f_s};
    end

    assign capture = sync_q[1] & ~sync_q[2];
    assign push    = capture & ~fifo_full;

    // A capture into a full FIFO is lost and flagged; a coincident clear loses.
    always_comb begin
        ovf_d = ovf_q;
        if (capture && fifo_full) ovf_d = 1'b1;
        else if (ovf_clr)         ovf_d = 1'b0;
    end

    // Sticky overflow flag register.
    always_ff @(posedge clk) begin
        if (!rst) ovf_q <= 1'b0;
        else      ovf_q <= ovf_d;
    end

    dac_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (sample_to_code(din)),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state and serializer next values. The frame is loaded on entry to
    // LOAD so cs_n is low and the MSB is already on sdo during the LOAD cycle.
    // In SHIFT, div counts clk cycles within an sclk half; last marks the
    // trailing low half after bit 0.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        last_d  = last_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        sdo_d   = sdo_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                cs_n_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = {DAC_CMD, fifo_data};
                    sdo_d   = DAC_CMD[7];
                    cs_n_d  = 1'b0;
                    bit_d   = TOP_BIT;
                    div_d   = '0;
                    last_d  = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 16'd1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        if (last_q) begin
                            cs_n_d  = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_GAP;
                        end else begin
                            sclk_d = 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 5'd0) begin
                            last_d = 1'b1;
                        end else begin
                            bit_d = bit_q - 5'd1;
                            sdo_d = shreg_q[bit_q - 5'd1];
                        end
                    end
                end
            end
            ST_GAP: begin
                if (div_q != GAP_LAST) begin
                    div_d = div_q + 16'd1;
                end else begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serializer registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            last_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            last_q  <= last_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
        end
    end

    // Output decode.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        dac_sclk   = sclk_q;
        dac_cs_n   = cs_n_q;
        dac_sdo    = sdo_q;
        frame_done = done_q;
        ovf        = ovf_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_filter_dac_out.sv
// Bench for filter_dac_out: two instances (CLK_DIV=1 and CLK_DIV=3), random
// samples, a timing-level queue model predicting accept/drop and frame order,
// and an SPI monitor decoding frames on rising sclk.
module tb_filter_dac_out;
  import filter_dac_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a = 1'b0, fs_a = 1'b0, clr_a = 1'b0;
  logic [15:0] din_a = '0;
  logic sclk_a, cs_a, sdo_a, busy_a, fd_a, ovf_a;
  logic [2:0] lvl_a;
  dac_state_t st_a;

  logic rst_b = 1'b0, fs_b = 1'b0, clr_b = 1'b0;
  logic [15:0] din_b = '0;
  logic sclk_b, cs_b, sdo_b, busy_b, fd_b, ovf_b;
  logic [2:0] lvl_b;
  dac_state_t st_b;

  filter_dac_out #(.CLK_DIV(1), .FIFO_DEPTH(DEPTH), .GAP_CYC(GAP), .DAC_CMD(8'h30)) dut_a (
    .clk(clk), .rst(rst_a), .out_f_s(fs_a), .din(din_a), .ovf_clr(clr_a),
    .dac_sclk(sclk_a), .dac_cs_n(cs_a), .dac_sdo(sdo_a), .busy(busy_a),
    .frame_done(fd_a), .ovf(ovf_a), .fifo_level(lvl_a), .dbg_state(st_a));

  filter_dac_out #(.CLK_DIV(3), .FIFO_DEPTH(DEPTH), .GAP_CYC(GAP), .DAC_CMD(8'h30)) dut_b (
    .clk(clk), .rst(rst_b), .out_f_s(fs_b), .din(din_b), .ovf_clr(clr_b),
    .dac_sclk(sclk_b), .dac_cs_n(cs_b), .dac_sdo(sdo_b), .busy(busy_b),
    .frame_done(fd_b), .ovf(ovf_b), .fifo_level(lvl_b), .dbg_state(st_b));

  int total_cnt = 0;
  int bad_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int cdiv(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int period(input int d);
    return 2 + 49 * cdiv(d) + GAP;
  endfunction

  function automatic logic [15:0] exp_code(input logic [15:0] s);
    int v;
`ifdef FILTER_DAC_OFFSET_BIN_EN
    v = int'(s) + 32768;
`else
    v = int'(s);
`endif
    return v[15:0];
  endfunction

  int acc_w[2][64];
  int acc_p[2][64];
  int acc_n[2] = '{0, 0};
  int last_pop[2] = '{-100000, -100000};
  logic ovf_exp[2] = '{1'b0, 1'b0};
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];

  // entries resident just before edge w
  function automatic int occ_before(input int d, input int w);
    int n = 0;
    for (int i = 0; i < acc_n[d]; i++)
      if (acc_w[d][i] < w && acc_p[d][i] >= w) n++;
    return n;
  endfunction

  // entries resident just after edge e
  function automatic int occ_after(input int d, input int e);
    int n = 0;
    for (int i = 0; i < acc_n[d]; i++)
      if (acc_w[d][i] <= e && acc_p[d][i] > e) n++;
    return n;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [31:0] lvl_of(input int d);
    return (d == 0) ? 32'(lvl_a) : 32'(lvl_b);
  endfunction

  function automatic logic [31:0] ovf_of(input int d);
    return (d == 0) ? 32'(ovf_a) : 32'(ovf_b);
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic cs_of(input int d);
    return (d == 0) ? cs_a : cs_b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_fs(input int d, input logic v, input logic [15:0] x);
    if (d == 0) begin fs_a = v; din_a = x; end
    else begin fs_b = v; din_b = x; end
  endtask

  task automatic drive_clr(input int d, input logic v);
    if (d == 0) clr_a = v;
    else clr_b = v;
  endtask

  // One strobe, 10 cycles long; called just after a negedge.
  task automatic strobe(input int d, input logic [15:0] x, input logic clr);
    int w;
    int p;
    w = cyc + 3;
    if (occ_before(d, w) >= DEPTH) begin
      ovf_exp[d] = 1'b1;
    end else begin
      if (clr) ovf_exp[d] = 1'b0;
      p = last_pop[d] + period(d);
      if (w + 1 > p) p = w + 1;
      last_pop[d] = p;
      if (acc_n[d] < 64) begin
        acc_w[d][acc_n[d]] = w;
        acc_p[d][acc_n[d]] = p;
        acc_n[d]++;
      end
      if (d == 0) exp_q0.push_back({8'h30, exp_code(x)});
      else exp_q1.push_back({8'h30, exp_code(x)});
    end
    drive_fs(d, 1'b1, x);
    @(negedge clk);
    @(negedge clk);
    if (clr) drive_clr(d, 1'b1);
    @(negedge clk);
    drive_clr(d, 1'b0);
    check("ovf_after_write", ovf_of(d), 32'(ovf_exp[d]));
    check("level_after_write", lvl_of(d), 32'(occ_after(d, cyc)));
    repeat (2) @(negedge clk);
    drive_fs(d, 1'b0, x);
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_drain(input int d, input int limit);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (qsize(d) == 0 && !busy_of(d) && lvl_of(d) == 0 && cs_of(d)) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_in_time", 32'(ok), 32'd1);
  endtask

  // ---------------- SPI monitor ----------------
  logic m_prev_sclk[2] = '{1'b0, 1'b0};
  logic m_prev_cs[2] = '{1'b1, 1'b1};
  int m_run[2] = '{0, 0};
  int m_bits[2] = '{0, 0};
  int m_low[2] = '{0, 0};
  int m_high[2] = '{0, 0};
  int m_frames[2] = '{0, 0};
  int m_fd[2] = '{0, 0};
  logic [23:0] m_sh[2] = '{24'd0, 24'd0};
  logic m_abort[2] = '{1'b0, 1'b0};

  task automatic mon_step(input int d, input logic sclk, input logic cs, input logic sdo, input logic fd);
    logic [23:0] e;
    if (fd === 1'b1) m_fd[d]++;
    if (cs === 1'b0) begin
      if (m_prev_cs[d] !== 1'b0) begin
        if (m_frames[d] > 0) check("gap_at_least", 32'(m_high[d] >= GAP), 32'd1);
        m_bits[d] = 0;
        m_low[d] = 1;
        m_run[d] = 1;
      end else begin
        m_low[d]++;
        if (sclk !== m_prev_sclk[d]) begin
          if (m_prev_sclk[d] === 1'b1 || m_bits[d] > 0)
            check("sclk_half_len", 32'(m_run[d]), 32'(cdiv(d)));
          if (sclk === 1'b1) begin
            m_bits[d]++;
            m_sh[d] = {m_sh[d][22:0], sdo};
          end
          m_run[d] = 1;
        end else begin
          m_run[d]++;
        end
      end
    end else begin
      if (m_prev_cs[d] === 1'b0) begin
        if (m_abort[d]) begin
          m_abort[d] = 1'b0;
        end else begin
          check("tail_low_len", 32'(m_run[d]), 32'(cdiv(d)));
          check("frame_bits", 32'(m_bits[d]), 32'd24);
          check("frame_done_at_end", 32'(fd), 32'd1);
          check("cs_low_len", 32'(m_low[d]), 32'(1 + 49 * cdiv(d)));
          if (qsize(d) == 0) begin
            check("frame_unexpected", 32'(m_sh[d]), 32'hFFFF_FFFF);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("frame_data", 32'(m_sh[d]), 32'(e));
          end
          m_frames[d]++;
        end
        m_high[d] = 1;
      end else begin
        m_high[d]++;
      end
    end
    m_prev_sclk[d] = sclk;
    m_prev_cs[d] = cs;
  endtask

  always @(negedge clk) begin
    mon_step(0, sclk_a, cs_a, sdo_a, fd_a);
    mon_step(1, sclk_b, cs_b, sdo_b, fd_b);
  end

  // ---------------- main sequence ----------------
  logic [15:0] dir_vals[4] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF};
  logic ok;

  initial begin
    // clock/reset
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    check("rst_sclk", 32'(sclk_a), 32'd0);
    check("rst_cs_n", 32'(cs_a), 32'd1);
    check("rst_sdo", 32'(sdo_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_frame_done", 32'(fd_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_level", 32'(lvl_a), 32'd0);
    check("rst_cs_n_b", 32'(cs_b), 32'd1);
    @(negedge clk);

    // directed codes, one frame each
    for (int i = 0; i < 4; i++) begin
      strobe(0, dir_vals[i], 1'b0);
      wait_drain(0, 300);
    end

    // strobes every 10 cycles while busy: drops and ovf set/clear interplay
    for (int i = 0; i < 10; i++) strobe(0, 16'($urandom), (i >= 6));
    drive_clr(0, 1'b1);
    @(negedge clk);
    drive_clr(0, 1'b0);
    ovf_exp[0] = 1'b0;
    check("ovf_clr_alone", ovf_of(0), 32'd0);
    wait_drain(0, 1500);

    // random samples with random spacing
    for (int i = 0; i < 6; i++) begin
      strobe(0, 16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_drain(0, 1500);

    // slow SPI clock instance
    strobe(1, 16'($urandom), 1'b0);
    strobe(1, 16'($urandom), 1'b0);
    wait_drain(1, 1000);

    // reset in the middle of bit 10
    strobe(0, 16'($urandom), 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_bits[0] == 13 && cs_a == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_bit10", 32'(ok), 32'd1);
    @(negedge clk);
    m_abort[0] = 1'b1;
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    exp_q0.delete();
    acc_n[0] = 0;
    last_pop[0] = -100000;
    ovf_exp[0] = 1'b0;
    check("abort_cs_n", 32'(cs_a), 32'd1);
    check("abort_sclk", 32'(sclk_a), 32'd0);
    check("abort_level", 32'(lvl_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ovf", 32'(ovf_a), 32'd0);
    repeat (80) @(negedge clk);
    check("no_frame_after_abort", 32'(cs_a), 32'd1);

    // final report
    check("frame_done_count_a", 32'(m_fd[0]), 32'(m_frames[0]));
    check("frame_done_count_b", 32'(m_fd[1]), 32'(m_frames[1]));
    check("frames_b", 32'(m_frames[1]), 32'd2);
    check("exp_q_empty_a", 32'(exp_q0.size()), 32'd0);
    check("exp_q_empty_b", 32'(exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
